// File: rtl/mac_pkg.sv
// Shared definitions for the round-robin MAC scheduler: FSM encoding and
// default widths of the MAC interface.
package mac_pkg;

    localparam int DATA_W_DEF  = 8;
    localparam int LEN_W_DEF   = 8;
    localparam int RES_W_DEF   = 22;
    localparam int TIMEOUT_DEF = 64;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_STREAM,
        ST_STOP,
        ST_RESP
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or above ptr, with wrap.
module rr_arbiter #(
    parameter int NREQ  = 2,
    parameter int PTR_W = 1
) (
    input  logic [NREQ-1:0]  req,
    input  logic [PTR_W-1:0] ptr,
    output logic [NREQ-1:0]  gnt_onehot,
    output logic [PTR_W-1:0] gnt_idx,
    output logic             gnt_valid
);

    logic [2*NREQ-1:0] dbl;
    logic [NREQ-1:0]   rot;
    logic [NREQ-1:0]   hit;
    logic [NREQ:0]     lower_any;
    logic [PTR_W-1:0]  idx_g   [NREQ];
    logic [PTR_W-1:0]  idx_acc [NREQ+1];

    // Rotating the request vector puts the pointer's requester at bit 0.
    assign dbl          = {req, req} >> ptr;
    assign rot          = dbl[NREQ-1:0];
    assign lower_any[0] = 1'b0;
    assign idx_acc[0]   = '0;

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_pick
            logic [PTR_W:0] sum;
            assign sum             = {1'b0, ptr} + (PTR_W+1)'(gi);
            assign idx_g[gi]       = (sum >= (PTR_W+1)'(NREQ)) ?
                                     PTR_W'(sum - (PTR_W+1)'(NREQ)) : sum[PTR_W-1:0];
            assign hit[gi]         = rot[gi] & ~lower_any[gi];
            assign lower_any[gi+1] = lower_any[gi] | rot[gi];
            assign idx_acc[gi+1]   = idx_acc[gi] | (hit[gi] ? idx_g[gi] : '0);
        end
    endgenerate

    assign gnt_valid = |req;
    assign gnt_idx   = idx_acc[NREQ];

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_onehot
            assign gnt_onehot[gi] = gnt_valid && (gnt_idx == PTR_W'(gi));
        end
    endgenerate

endmodule

// File: rtl/mac_rr_scheduler.sv
// Shares one MAC engine between NREQ requesters: round-robin grant, then
// go / operand streaming / stop, and returns the final result to the owner.
module mac_rr_scheduler
    import mac_pkg::*;
#(
    parameter int NREQ    = 2,
    parameter int LEN_W   = LEN_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int RES_W   = RES_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ*LEN_W-1:0]  req_len,
    input  logic [NREQ-1:0]        op_valid,
    input  logic [NREQ*DATA_W-1:0] op_a,
    input  logic [NREQ*DATA_W-1:0] op_b,
    output logic [NREQ-1:0]        op_ready,
    output logic [NREQ-1:0]        grant,
    output logic [NREQ-1:0]        resp_valid,
    output logic [RES_W-1:0]       resp_result,
    output logic                   resp_err,
    output logic                   mac_go,
    output logic                   mac_stop,
    output logic [DATA_W-1:0]      mac_a,
    output logic [DATA_W-1:0]      mac_b,
    input  logic                   mac_idle,
    input  logic                   mac_done,
    input  logic [RES_W-1:0]       mac_result
);

    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int TO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    logic [DATA_W-1:0] a_arr   [NREQ];
    logic [DATA_W-1:0] b_arr   [NREQ];
    logic [LEN_W-1:0]  len_arr [NREQ];

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign a_arr[gi]   = op_a[gi*DATA_W +: DATA_W];
            assign b_arr[gi]   = op_b[gi*DATA_W +: DATA_W];
            assign len_arr[gi] = req_len[gi*LEN_W +: LEN_W];
        end
    endgenerate

    state_t            state_reg;
    logic [PTR_W-1:0]  ptr_reg;
    logic [PTR_W-1:0]  owner_reg;
    logic [LEN_W-1:0]  len_reg;
    logic [LEN_W-1:0]  beat_reg;
    logic [TO_W-1:0]   to_cnt_reg;
    logic [NREQ-1:0]   grant_reg;
    logic [NREQ-1:0]   resp_valid_reg;
    logic [RES_W-1:0]  resp_result_reg;
    logic              resp_err_reg;
    logic              mac_go_reg;
    logic              mac_stop_reg;

    logic [NREQ-1:0]   arb_onehot;
    logic [PTR_W-1:0]  arb_idx;
    logic              arb_valid;
    logic              in_stream;
    logic              accept;
    logic [PTR_W-1:0]  ptr_next;

    rr_arbiter #(
        .NREQ  (NREQ),
        .PTR_W (PTR_W)
    ) u_arb (
        .req        (req),
        .ptr        (ptr_reg),
        .gnt_onehot (arb_onehot),
        .gnt_idx    (arb_idx),
        .gnt_valid  (arb_valid)
    );

    // Bubbles feed zeros so the MAC accumulates nothing on idle beats.
    assign in_stream = (state_reg == ST_STREAM);
    assign accept    = in_stream && op_valid[owner_reg];
    assign op_ready  = in_stream ? grant_reg : '0;
    assign mac_a     = accept ? a_arr[owner_reg] : '0;
    assign mac_b     = accept ? b_arr[owner_reg] : '0;
    assign ptr_next  = (owner_reg == PTR_W'(NREQ - 1)) ? '0 : owner_reg + PTR_W'(1);

    assign grant       = grant_reg;
    assign resp_valid  = resp_valid_reg;
    assign resp_result = resp_result_reg;
    assign resp_err    = resp_err_reg;
    assign mac_go      = mac_go_reg;
    assign mac_stop    = mac_stop_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= ST_IDLE;
            ptr_reg         <= '0;
            owner_reg       <= '0;
            len_reg         <= '0;
            beat_reg        <= '0;
            to_cnt_reg      <= '0;
            grant_reg       <= '0;
            resp_valid_reg  <= '0;
            resp_result_reg <= '0;
            resp_err_reg    <= 1'b0;
            mac_go_reg      <= 1'b0;
            mac_stop_reg    <= 1'b0;
        end else begin
            mac_go_reg     <= 1'b0;
            resp_valid_reg <= '0;
            case (state_reg)
                ST_IDLE: begin
                    if (mac_idle && arb_valid) begin
                        owner_reg <= arb_idx;
                        len_reg   <= len_arr[arb_idx];
                        grant_reg <= arb_onehot;
                        beat_reg  <= '0;
                        if (len_arr[arb_idx] != '0) begin
                            state_reg  <= ST_START;
                            mac_go_reg <= 1'b1;
                        end else begin
                            state_reg       <= ST_RESP;
                            resp_valid_reg  <= arb_onehot;
                            resp_result_reg <= '0;
                            resp_err_reg    <= 1'b0;
                        end
                    end
                end
                ST_START: begin
                    beat_reg  <= '0;
                    state_reg <= ST_STREAM;
                end
                ST_STREAM: begin
                    if (accept) begin
                        if (beat_reg == len_reg - LEN_W'(1)) begin
                            state_reg    <= ST_STOP;
                            mac_stop_reg <= 1'b1;
                            to_cnt_reg   <= '0;
                        end else begin
                            beat_reg <= beat_reg + LEN_W'(1);
                        end
                    end
                end
                ST_STOP: begin
                    if (mac_done) begin
                        state_reg       <= ST_RESP;
                        mac_stop_reg    <= 1'b0;
                        resp_valid_reg  <= grant_reg;
                        resp_result_reg <= mac_result;
                        resp_err_reg    <= 1'b0;
                    end else if (to_cnt_reg == TO_LAST) begin
                        state_reg       <= ST_RESP;
                        mac_stop_reg    <= 1'b0;
                        resp_valid_reg  <= grant_reg;
                        resp_result_reg <= '0;
                        resp_err_reg    <= 1'b1;
                    end else begin
                        to_cnt_reg <= to_cnt_reg + TO_W'(1);
                    end
                end
                ST_RESP: begin
                    grant_reg <= '0;
                    ptr_reg   <= ptr_next;
                    state_reg <= ST_IDLE;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule
